// File: rtl/arb21_16.sv
// Two-requester round-robin arbiter with a registered 16-bit output stage.
// Define ARB_BURST_EN to let one requester keep the grant for up to BURST consecutive words.
module arb21_16 #(
    parameter int W     = 16,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         v0,
    input  logic [W-1:0] d0,
    output logic         rdy0,
    input  logic         v1,
    input  logic [W-1:0] d1,
    output logic         rdy1,
    output logic         out_v,
    output logic [W-1:0] out_d,
    input  logic         out_rdy,
    output logic         sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    logic   pri;
    logic   accept;
    logic   win;
    logic   xfer;
    logic   pri_n;

    // The burst counter is 4 bits wide, so BURST must fit in 1..15.
    if (BURST < 1 || BURST > 15) begin : g_burst_range
        $error("arb21_16: BURST must be in 1..15");
    end

    assign out_v  = (state == FULL);
    assign accept = !out_v || out_rdy;

    // Contention is resolved by pri; a lone requester always wins.
    assign win  = (v0 && v1) ? pri : v1;
    assign xfer = accept && (v0 || v1) && !rst;
    assign rdy0 = xfer && !win;
    assign rdy1 = xfer && win;

`ifdef ARB_BURST_EN
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic       yield;

    // cnt==0 means no owner yet; a full burst starts a fresh one if nobody competes.
    always_comb begin
        cnt_n = 4'd1;
        if ((win == sel) && (cnt != 4'd0) && (cnt < 4'(BURST))) begin
            cnt_n = cnt + 4'd1;
        end
        pri_n = (cnt_n < 4'(BURST)) ? win : !win;
    end

    // The priority holder gave up its slot while the other side is waiting.
    assign yield = pri ? (!v1 && v0) : (!v0 && v1);
`else
    assign pri_n = !win;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            out_d <= '0;
            sel   <= 1'b0;
            pri   <= 1'b0;
`ifdef ARB_BURST_EN
            cnt   <= 4'd0;
`endif
        end else if (xfer) begin
            state <= FULL;
            out_d <= win ? d1 : d0;
            sel   <= win;
            pri   <= pri_n;
`ifdef ARB_BURST_EN
            cnt   <= cnt_n;
`endif
        end else begin
            if (out_v && out_rdy) begin
                state <= EMPTY;
            end
`ifdef ARB_BURST_EN
            if (yield) begin
                pri <= !pri;
            end
`endif
        end
    end

endmodule

// File: doc/arb21_16.md
Name: arb21_16

Overview:
- Two-requester round-robin arbiter and output register for the 16-bit 2:1 bus mux.
- Shares a single 16-bit downstream channel between requester 0 and requester 1 using valid/ready handshakes.
- Drives the mux select, registers the winning word, and presents it downstream with 1-cycle latency.
- Sits in front of any single-port consumer that two producers must share.

Parameters:
- W, 16, data width of each requester and of the output.
- BURST, 4, maximum consecutive transfers granted to one requester; used only when ARB_BURST_EN is defined; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- v0  input  1  requester 0 has a word.
- d0  input  W  requester 0 data.
- rdy0  output  1  requester 0 word accepted this cycle when v0 is also high.
- v1  input  1  requester 1 has a word.
- d1  input  W  requester 1 data.
- rdy1  output  1  requester 1 word accepted this cycle when v1 is also high.
- out_v  output  1  output register holds a valid word.
- out_d  output  W  output data.
- out_rdy  input  1  downstream accepts out_d this cycle.
- sel  output  1  registered mux select; identifies the source of the word in out_d (0 = requester 0, 1 = requester 1).

Behaviour:
- Reset (rst high at a clock edge):
  - out_v=0, out_d=0, sel=0.
  - Priority pointer pri=0.
  - Burst counter=0.
  - Any word held in the output register is discarded.
  - rdy0 and rdy1 are combinational and are forced to 0 while rst is high.
- accept = !out_v | out_rdy. The output register can load in any cycle where accept is high.
- Winner selection (combinational):
  - Only v0 high: winner is 0.
  - Only v1 high: winner is 1.
  - Both high: winner = pri.
  - Neither high: no winner.
- rdy_k = accept & (winner==k). At most one of rdy0/rdy1 is high in any cycle.
- Transfer from k occurs on a cycle where v_k & rdy_k. At the next edge:
  - out_d <= d_k.
  - sel <= k.
  - out_v <= 1.
  - pri <= ~k (round-robin).
- Pop: out_v & out_rdy with no new transfer in the same cycle -> out_v <= 0.
- Simultaneous pop and transfer: register reloads with the new word; out_v stays 1. This gives full throughput of 1 word per clock.
- Stall: while out_v & !out_rdy, out_d and sel are held stable and rdy0=rdy1=0.
- out_v=0: out_d and sel keep their last values.
- Latency: a word accepted at cycle n is visible on out_d at cycle n+1.
- Fairness: with both requesters continuously valid and out_rdy=1, grants alternate 0,1,0,1,...
- A requester with no competitor may transfer every cycle.
- pri changes only on a transfer; idle cycles do not move it.
- Data width rule: W-bit words pass through unmodified; no truncation or extension.
- State summary:
  - EMPTY (out_v=0) -> FULL on transfer.
  - FULL -> EMPTY on pop without a transfer.
  - FULL -> FULL on stall, or on pop combined with a transfer.

Optional Feature:
- Macro: ARB_BURST_EN.
- Defined:
  - A burst counter tracks consecutive transfers from the current owner.
  - After a transfer from k, pri stays k while the counter is below BURST and v_k remains high.
  - pri moves to ~k when the counter reaches BURST, or when v_k is low for a cycle in which the other requester is valid.
  - The counter resets to 1 whenever ownership changes, and to 0 on reset.
  - Worst-case wait for the losing requester is BURST transfers.
- Undefined: no counter is built; behaviour is strict per-word round-robin as described above.

Test Plan:
- Reset, then v0=1 with d0=16'hA5A5 and out_rdy=1 -> rdy0=1 that cycle; next cycle out_v=1, out_d=16'hA5A5, sel=0.
- v0=v1=1 continuously with d0=16'h0001, d1=16'h0002, out_rdy=1 -> out_d sequence 0001, 0002, 0001, 0002; sel toggles 0,1,0,1.
- Load one word, then hold out_rdy=0 for 3 cycles while v1=1 with d1=16'hBEEF -> rdy0=rdy1=0 and out_d stable; after out_rdy rises, 16'hBEEF appears the cycle after it is accepted.
- Register full with out_rdy=1 and v1=1 in the same cycle -> out_v stays 1 and out_d updates to d1 with no bubble.
- Assert rst while out_v=1 and both requesters valid -> next cycle out_v=0, out_d=0, sel=0; first grant after reset goes to requester 0.
- With ARB_BURST_EN defined and BURST=4, both requesters continuously valid -> sel pattern 0,0,0,0,1,1,1,1,0,...
